// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller with IR, bypass, IDCODE and BSR control

module jtag_tap_ctrl #(
    parameter int          IR_LEN     = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1923_4001
) (
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       TDO_BSR,
    output logic       TDO,
    output logic       TDO_EN,
    output logic       clockdr,
    output logic       shiftdr,
    output logic       updatedr,
    output logic       bs_en,
    output logic [3:0] tap_state
);

    typedef enum logic [3:0] {
        TLR   = 4'h0,
        RTI   = 4'h1,
        SELDR = 4'h2,
        CAPDR = 4'h3,
        SHDR  = 4'h4,
        EX1DR = 4'h5,
        PAUDR = 4'h6,
        EX2DR = 4'h7,
        UPDDR = 4'h8,
        SELIR = 4'h9,
        CAPIR = 4'hA,
        SHIR  = 4'hB,
        EX1IR = 4'hC,
        PAUIR = 4'hD,
        EX2IR = 4'hE,
        UPDIR = 4'hF
    } tap_state_t;

    localparam logic [IR_LEN-1:0] INS_EXTEST = '0;
    localparam logic [IR_LEN-1:0] INS_SAMPLE = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] INS_IDCODE = IR_LEN'(2);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

    tap_state_t        state;
    tap_state_t        state_nxt;
    logic [IR_LEN-1:0] ir_active;
    logic [IR_LEN-1:0] ir_nxt;
    logic [IR_LEN-1:0] ir_shift;
    logic              bypass_reg;
    logic [31:0]       id_reg;
    logic [1:0]        rst_sync;
    logic              rst_int_n;

    // EXTEST and SAMPLE both route the data path through the external boundary-scan chain
    function automatic logic is_bsr(input logic [IR_LEN-1:0] ir);
        return (ir == INS_EXTEST) || (ir == INS_SAMPLE);
    endfunction

    // Every code that is not a defined instruction falls back to the bypass register
    function automatic logic is_bypass(input logic [IR_LEN-1:0] ir);
        return !is_bsr(ir) && (ir != INS_IDCODE);
    endfunction

    // Assert internal reset immediately, release it only after two TCK rises
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // TAP state transition graph driven by TMS
    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:   state_nxt = TMS ? TLR   : RTI;
            RTI:   state_nxt = TMS ? SELDR : RTI;
            SELDR: state_nxt = TMS ? SELIR : CAPDR;
            CAPDR: state_nxt = TMS ? EX1DR : SHDR;
            SHDR:  state_nxt = TMS ? EX1DR : SHDR;
            EX1DR: state_nxt = TMS ? UPDDR : PAUDR;
            PAUDR: state_nxt = TMS ? EX2DR : PAUDR;
            EX2DR: state_nxt = TMS ? UPDDR : SHDR;
            UPDDR: state_nxt = TMS ? SELDR : RTI;
            SELIR: state_nxt = TMS ? TLR   : CAPIR;
            CAPIR: state_nxt = TMS ? EX1IR : SHIR;
            SHIR:  state_nxt = TMS ? EX1IR : SHIR;
            EX1IR: state_nxt = TMS ? UPDIR : PAUIR;
            PAUIR: state_nxt = TMS ? EX2IR : PAUIR;
            EX2IR: state_nxt = TMS ? UPDIR : SHIR;
            UPDIR: state_nxt = TMS ? SELDR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // Active instruction: forced to IDCODE on the edge that lands in TLR, loaded only on the UpdIR edge
    always_comb begin
        ir_nxt = ir_active;
        if (state_nxt == TLR) begin
            ir_nxt = INS_IDCODE;
        end else if (state == UPDIR) begin
            ir_nxt = ir_shift;
        end
    end

    // State, shift paths and the flopped BSR strobes; strobes are computed from the next
    // state and instruction so they equal the decode of the current registers without glitches
    always_ff @(posedge TCK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= TLR;
            ir_active  <= INS_IDCODE;
            ir_shift   <= IR_CAPTURE;
            bypass_reg <= 1'b0;
            id_reg     <= IDCODE_VAL;
            bs_en      <= 1'b0;
            clockdr    <= 1'b0;
            shiftdr    <= 1'b0;
            updatedr   <= 1'b0;
            TDO_EN     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ir_active <= ir_nxt;
            bs_en     <= (ir_nxt == INS_EXTEST);
            case (state)
                CAPIR: ir_shift <= IR_CAPTURE;
                SHIR:  ir_shift <= {TDI, ir_shift[IR_LEN-1:1]};
                CAPDR: begin
                    bypass_reg <= 1'b0;
                    id_reg     <= IDCODE_VAL;
                end
                SHDR: begin
                    if (is_bypass(ir_active)) begin
                        bypass_reg <= TDI;
                    end
                    if (ir_active == INS_IDCODE) begin
                        id_reg <= {TDI, id_reg[31:1]};
                    end
                end
                default: ;
            endcase
            clockdr  <= is_bsr(ir_nxt) && ((state_nxt == CAPDR) || (state_nxt == SHDR));
            shiftdr  <= (state_nxt == SHDR);
            updatedr <= is_bsr(ir_nxt) && (state_nxt == UPDDR);
            TDO_EN   <= (state_nxt == SHDR) || (state_nxt == SHIR);
        end
    end

    // Serial output mux: LSB of whichever path is currently shifting, otherwise 0
    always_comb begin
        TDO = 1'b0;
        if (state == SHIR) begin
            TDO = ir_shift[0];
        end else if (state == SHDR) begin
            if (is_bsr(ir_active)) begin
                TDO = TDO_BSR;
            end else if (ir_active == INS_IDCODE) begin
                TDO = id_reg[0];
            end else begin
                TDO = bypass_reg;
            end
        end
    end

    assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - randomized self-checking bench for jtag_tap_ctrl

module tb_jtag_tap_ctrl;

    localparam logic [31:0] ID = 32'h1923_4001;

    logic       TCK = 1'b0;
    logic       TRST_N;
    logic       TMS;
    logic       TDI;
    logic       TDO_BSR;
    logic       TDO;
    logic       TDO_EN;
    logic       clockdr;
    logic       shiftdr;
    logic       updatedr;
    logic       bs_en;
    logic [3:0] tap_state;

    jtag_tap_ctrl #(.IR_LEN(4), .IDCODE_VAL(ID)) dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO_BSR(TDO_BSR),
        .TDO(TDO), .TDO_EN(TDO_EN), .clockdr(clockdr), .shiftdr(shiftdr),
        .updatedr(updatedr), .bs_en(bs_en), .tap_state(tap_state)
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: state graph table, active instruction, and the selected path as a FIFO
    int         nxt [16][2];
    int         m_state;
    logic [3:0] m_ir;
    bit         q[$];
    int         hold;
    logic       s_tdo;
    int         cnt_clk;
    int         cnt_upd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        logic e_tdo;
        logic bsr;
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        TDO_BSR = 1'($urandom_range(0, 1));
        #2;
        bsr = (m_ir == 4'h0) || (m_ir == 4'h1);
        e_tdo = 1'b0;
        if (m_state == 11) e_tdo = q[0];
        else if (m_state == 4) e_tdo = bsr ? TDO_BSR : q[0];
        s_tdo = TDO;
        cnt_clk += int'(clockdr);
        cnt_upd += int'(updatedr);
        check("tap_state", tap_state, m_state);
        check("tdo", TDO, e_tdo);
        check("tdo_en", TDO_EN, (m_state == 4) || (m_state == 11));
        check("shiftdr", shiftdr, m_state == 4);
        check("clockdr", clockdr, bsr && ((m_state == 3) || (m_state == 4)));
        check("updatedr", updatedr, bsr && (m_state == 8));
        check("bs_en", bs_en, m_ir == 4'h0);
        @(posedge TCK);
        if (hold > 0) begin
            hold--;
        end else begin
            case (m_state)
                10: q = '{1'b1, 1'b0, 1'b0, 1'b0};
                3: begin
                    q.delete();
                    if (m_ir == 4'h2) for (int i = 0; i < 32; i++) q.push_back(ID[i]);
                    else q.push_back(1'b0);
                end
                11: begin void'(q.pop_front()); q.push_back(tdi); end
                4: if (!bsr) begin void'(q.pop_front()); q.push_back(tdi); end
                15: m_ir = {q[3], q[2], q[1], q[0]};
                default: ;
            endcase
            m_state = nxt[m_state][int'(tms)];
            if (m_state == 0) m_ir = 4'h2;
        end
    endtask

    task automatic do_reset();
        @(posedge TCK);
        #3 TRST_N = 1'b0;
        #1;
        check("rst_tdo", TDO, 0);
        check("rst_tdo_en", TDO_EN, 0);
        check("rst_clockdr", clockdr, 0);
        check("rst_shiftdr", shiftdr, 0);
        check("rst_updatedr", updatedr, 0);
        check("rst_bs_en", bs_en, 0);
        check("rst_state", tap_state, 0);
        @(posedge TCK);
        @(posedge TCK);
        #1 TRST_N = 1'b1;
        m_state = 0;
        m_ir = 4'h2;
        q.delete();
        hold = 2;
    endtask

    task automatic go_rti();
        if (m_state != 1) begin
            repeat (5) tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic pause_seq();
        tick(1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom_range(0, 1)));
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic ir_scan(input logic [3:0] v, input bit pause, output logic [3:0] bits);
        bit p;
        go_rti();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            p = pause && (i == 1);
            tick((i == 3) || p, v[i]);
            bits[i] = s_tdo;
            if (p) pause_seq();
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int n, input logic [63:0] din, input bit pause,
                           output logic [63:0] bits);
        bit p;
        bits = '0;
        go_rti();
        cnt_clk = 0;
        cnt_upd = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            p = pause && (i == n / 2) && (i != n - 1);
            tick((i == n - 1) || p, din[i]);
            bits[i] = s_tdo;
            if (p) pause_seq();
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ib;
        logic [63:0] db;
        logic [3:0]  v;
        int          cnt;
        nxt = '{'{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8}, '{6, 7}, '{4, 8},
                '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}};
        TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; TDO_BSR = 1'b0;
        cnt_clk = 0; cnt_upd = 0; s_tdo = 1'b0;
        m_state = 0; m_ir = 4'h2; hold = 2;
        do_reset();

        // two-flop release: no state change before the third rise after release
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #1 check("sync_hold", tap_state, 0);
        tick(1'b0, 1'b0);
        #1 check("sync_first_move", tap_state, 1);

        // IDCODE readout after reset
        dr_scan(32, 64'h0, 1'b0, db);
        check("idcode_read", db[31:0], ID);

        // EXTEST: bs_en and BSR strobes
        ir_scan(4'h0, 1'b0, ib);
        #1 check("extest_bs_en", bs_en, 1);
        dr_scan(8, {$urandom, $urandom}, 1'b0, db);
        check("extest_clk_cnt", cnt_clk, 9);
        check("extest_upd_cnt", cnt_upd, 1);

        // BYPASS: capture pattern and 1-cycle delay
        ir_scan(4'hF, 1'b0, ib);
        check("ir_capture", ib, 4'b0001);
        dr_scan(4, 64'b1101, 1'b0, db);
        check("bypass_delay", db[3:0], 4'b1010);

        // SAMPLE mirrors the chain without enabling it
        ir_scan(4'h1, 1'b0, ib);
        dr_scan(12, {$urandom, $urandom}, 1'b1, db);
        check("sample_upd_cnt", cnt_upd, 1);
        #1 check("sample_bs_en", bs_en, 0);

        // reset in the middle of an IR shift aborts the load
        go_rti();
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        do_reset();
        #1 check("abort_bs_en", bs_en, 0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        dr_scan(32, 64'h0, 1'b0, db);
        check("abort_idcode", db[31:0], ID);

        // five TMS=1 clocks reach TLR from every state
        for (int s = 0; s < 16; s++) begin
            if (s % 2 == 1) ir_scan(4'h0, 1'b0, ib);
            cnt = 0;
            while ((m_state != s) && (cnt < 500)) begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                cnt++;
            end
            #1 check("walk_reach", tap_state, s);
            repeat (5) tick(1'b1, 1'b0);
            #1 check("tlr_state", tap_state, 0);
            check("tlr_bs_en", bs_en, 0);
        end

        // randomized scans checked cycle by cycle against the model
        for (int k = 0; k < 50; k++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: begin
                    case ($urandom_range(0, 4))
                        0: v = 4'h0;
                        1: v = 4'h1;
                        2: v = 4'h2;
                        3: v = 4'hF;
                        default: v = 4'($urandom_range(0, 15));
                    endcase
                    ir_scan(v, 1'($urandom_range(0, 1)), ib);
                end
                7: do_reset();
                default: dr_scan($urandom_range(1, 40), {$urandom, $urandom},
                                 1'($urandom_range(0, 1)), db);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameter IR_LEN, 4, instruction register width in bits.
REQ-002 Parameter IDCODE_VAL, 32'h1923_4001, device ID; bit 0 SHALL be 1.
REQ-003 TCK  input  1  sole clock; all state updates on rising edge.
REQ-004 TRST_N  input  1  asynchronous active-low reset.
REQ-005 TMS  input  1  test mode select, sampled on TCK rise.
REQ-006 TDI  input  1  serial data in; also feeds the downstream BSR TDI.
REQ-007 TDO_BSR  input  1  serial out of the downstream boundary-scan chain.
REQ-008 TDO  output  1  serial data out, LSB of the selected shift path.
REQ-009 TDO_EN  output  1  high only in Shift-DR or Shift-IR.
REQ-010 clockdr  output  1  BSR capture/shift strobe.
REQ-011 shiftdr  output  1  BSR shift select (1 = shift, 0 = capture).
REQ-012 updatedr  output  1  BSR update strobe.
REQ-013 bs_en  output  1  BSR drives CUT inputs/pins (EXTEST active).
REQ-014 tap_state  output  4  current TAP state encoding, for debug.

Function
REQ-015 The FSM SHALL implement the 16 IEEE 1149.1 TAP states.
- Encoding: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=A, ShIR=B, Ex1IR=C, PauIR=D, Ex2IR=E, UpdIR=F.
REQ-016 State transitions SHALL be (TMS=0 / TMS=1):
- TLR: RTI/TLR
- RTI: RTI/SelDR
- SelDR: CapDR/SelIR
- SelIR: CapIR/TLR
- CapX: ShX/Ex1X
- ShX: ShX/Ex1X
- Ex1X: PauX/UpdX
- PauX: PauX/Ex2X
- Ex2X: ShX/UpdX
- UpdX: RTI/SelDR
REQ-017 Instructions: EXTEST=4'b0000, SAMPLE=4'b0001, IDCODE=4'b0010, BYPASS=4'b1111; any other code SHALL decode as BYPASS.
REQ-018 IR shift register behaviour:
- CapIR: loads 4'b0001.
- ShIR: shifts right, TDI into MSB.
- Active IR: loaded from the shift register on the UpdIR clock edge only.
REQ-019 Bypass register: 1 bit; cleared in CapDR; loads TDI in ShDR when BYPASS is active.
REQ-020 ID register: 32 bits; loads IDCODE_VAL in CapDR; shifts right with TDI into bit 31 in ShDR when IDCODE is active.
REQ-021 BSR selection: BSR is selected when the active IR is EXTEST or SAMPLE.
- clockdr = BSR selected & state in {CapDR, ShDR}.
- shiftdr = (state == ShDR).
- updatedr = BSR selected & state == UpdDR.
- All three SHALL be decoded combinationally from registered state and active IR, and SHALL be glitch-free.
REQ-022 bs_en SHALL equal (active IR == EXTEST) and change only on the UpdIR edge or on reset.
REQ-023 TDO source selection:
- ShIR: IR shift LSB.
- ShDR: bypass bit, ID LSB, or TDO_BSR, per active IR.
- All other states: 0.
REQ-024 Entering TLR by TMS SHALL force the active IR to IDCODE and bs_en to 0 on the next edge.
REQ-025 Pause states SHALL hold all shift registers unchanged; no strobe is asserted in them.
REQ-026 SelDR and SelIR SHALL NOT modify any register.

Reset
REQ-027 TRST_N low SHALL immediately, without TCK, set:
- state = TLR
- active IR = IDCODE
- IR shift = 4'b0001
- bypass = 0
- ID register = IDCODE_VAL
REQ-028 During reset: TDO=0, TDO_EN=0, clockdr=0, shiftdr=0, updatedr=0, bs_en=0, tap_state=0.
REQ-029 Reset deassertion SHALL be synchronized to TCK (two-flop release); the first state change occurs no earlier than the second TCK rise after TRST_N rises.
REQ-030 TRST_N asserted mid-shift SHALL abort the scan with no update of the active IR.

Verification
REQ-031 From each of the 16 states, 5 TCK cycles with TMS=1 -> tap_state=0 (TLR), bs_en=0.
REQ-032 After reset, TMS 0,1,0,0 then 32 ShDR cycles -> TDO emits 32'h1923_4001 LSB first; TDO_EN=1 throughout.
REQ-033 IR scan of 4'b0000 ending in UpdIR -> bs_en=1 after that edge; on the next DR scan, clockdr is high in CapDR and ShDR and updatedr is high for exactly 1 cycle in UpdDR.
REQ-034 IR scan shifting in 4'b1111 -> first 4 TDO bits read 1,0,0,0 (capture 0001); then a DR scan with TDI pattern 1,0,1,1 -> TDO is 0,1,0,1 (1-cycle delay).
REQ-035 IR=SAMPLE with TDO_BSR toggling -> TDO mirrors TDO_BSR in ShDR; bs_en stays 0.
REQ-036 TRST_N pulsed low during ShIR after 2 of 4 bits -> active IR remains IDCODE; all outputs match REQ-028 asynchronously.
